// File: rtl/memory_stage_if.sv
// ---------------------------------------------------------------------------
// memory_stage_if
//   Word-wide data-memory port between the MEM pipeline stage (master) and
//   the data memory (slave).
//
//   Handshake: the master holds DM_REQ high, with DM_WE/DM_ADDR/DM_WDATA
//   stable, until the slave returns DM_ACK=1. The access completes on the
//   posedge where DM_REQ=1 and DM_ACK=1 are both seen. DM_RDATA is only
//   meaningful in that cycle. DM_ACK without DM_REQ has no meaning.
//
//   Signals
//     DM_REQ    master->slave  access request
//     DM_WE     master->slave  1 = write, 0 = read
//     DM_ADDR   master->slave  word address
//     DM_WDATA  master->slave  store data
//     DM_ACK    slave->master  access complete this cycle
//     DM_RDATA  slave->master  load data, valid with DM_ACK
// ---------------------------------------------------------------------------
interface memory_stage_if #(
  parameter int W = 32
);
  logic         DM_REQ;
  logic         DM_WE;
  logic [W-1:0] DM_ADDR;
  logic [W-1:0] DM_WDATA;
  logic         DM_ACK;
  logic [W-1:0] DM_RDATA;

  modport master (
    output DM_REQ, DM_WE, DM_ADDR, DM_WDATA,
    input  DM_ACK, DM_RDATA
  );

  modport slave (
    input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA,
    output DM_ACK, DM_RDATA
  );
endinterface

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   MEM pipeline stage. Takes the EX/MEM register outputs, performs a word
//   load or store over the req/ack data-memory port, and produces the MEM/WB
//   register, the EX forwarding value and a stall for upstream stages while
//   an access is outstanding. Accesses that wait too long are aborted.
//
//   Ports
//     clk, rst     clock, synchronous active-high reset
//     ALU_OUT      EX result, also the ld/st address
//     RD           destination register
//     MEM_WE_ME    store request (wins over MEM_REG_ME)
//     ME_WE        register-file write enable
//     MEM_REG_ME   load request
//     WD_ME        store data
//     dm           data-memory port (master side)
//     BP_MEM       forwarding value for EX (= ALU_OUT)
//     MEM_STALL    hold EX and earlier stages this cycle
//     WB_DATA/WB_RD/WB_WE  MEM/WB register
//     MISALIGN     one-cycle pulse: misaligned ld/st dropped
//     BUS_ERR      one-cycle pulse: access aborted on timeout
//     o_dbg_state  FSM state (0 = IDLE, 1 = WAIT)
// ---------------------------------------------------------------------------
module memory_stage #(
  parameter int INST_SIZE   = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INST_SIZE-1:0] ALU_OUT,
  input  logic [4:0]           RD,
  input  logic                 MEM_WE_ME,
  input  logic                 ME_WE,
  input  logic                 MEM_REG_ME,
  input  logic [INST_SIZE-1:0] WD_ME,
  memory_stage_if.master       dm,
  output logic [INST_SIZE-1:0] BP_MEM,
  output logic                 MEM_STALL,
  output logic [INST_SIZE-1:0] WB_DATA,
  output logic [4:0]           WB_RD,
  output logic                 WB_WE,
  output logic                 MISALIGN,
  output logic                 BUS_ERR,
  output logic                 o_dbg_state
);

  localparam logic [7:0] L_TIMEOUT = TIMEOUT_CYC[7:0];

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [INST_SIZE-1:0] r_wb_data;
  logic [4:0]           r_wb_rd;
  logic                 r_wb_we;
  logic                 r_misalign;
  logic                 r_bus_err;

  logic w_access;
  logic w_store;
  logic w_load;
  logic w_misalign;
  logic w_is_wait;
  logic w_timeout;
  logic w_abort;
  logic w_req;
  logic w_stall;

  assign w_access   = MEM_WE_ME | MEM_REG_ME;
  assign w_store    = MEM_WE_ME;
  assign w_load     = MEM_REG_ME & ~MEM_WE_ME;
  assign w_misalign = w_access & (ALU_OUT[1:0] != 2'b00);
  assign w_is_wait  = (r_state == S_WAIT);
  assign w_timeout  = w_is_wait & (r_cnt == L_TIMEOUT);
  // Ack in the last allowed cycle still completes; abort only without it.
  assign w_abort    = w_timeout & ~dm.DM_ACK;

  // Request is held for the whole WAIT period; reset kills it immediately.
  assign w_req   = ~rst & ((~w_is_wait & w_access & ~w_misalign) | w_is_wait);
  // The abort cycle releases the pipeline so the dropped op moves on.
  assign w_stall = w_req & ~dm.DM_ACK & ~w_timeout;

  assign dm.DM_REQ   = w_req;
  assign dm.DM_WE    = w_store;
  assign dm.DM_ADDR  = ALU_OUT;
  assign dm.DM_WDATA = WD_ME;

  assign BP_MEM      = ALU_OUT;
  assign MEM_STALL   = w_stall;
  assign WB_DATA     = r_wb_data;
  assign WB_RD       = r_wb_rd;
  assign WB_WE       = r_wb_we;
  assign MISALIGN    = r_misalign;
  assign BUS_ERR     = r_bus_err;
  assign o_dbg_state = w_is_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_wb_data  <= '0;
      r_wb_rd    <= 5'd0;
      r_wb_we    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req && !dm.DM_ACK) begin
            r_state <= S_WAIT;
            r_cnt   <= 8'd1;
          end
        end
        S_WAIT: begin
          if (dm.DM_ACK || w_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
        end
      endcase

      // MEM/WB register: bubble while stalled, drop on abort or misalign,
      // otherwise capture the finished op.
      if (w_stall) begin
        r_wb_we <= 1'b0;
      end else if (w_abort) begin
        r_wb_we   <= 1'b0;
        r_bus_err <= 1'b1;
      end else if (!w_is_wait && w_misalign) begin
        r_wb_we    <= 1'b0;
        r_misalign <= 1'b1;
      end else begin
        r_wb_data <= w_load ? dm.DM_RDATA : ALU_OUT;
        r_wb_rd   <= RD;
        r_wb_we   <= ME_WE & (RD != 5'd0) & ~w_store;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int W = 32;
  localparam int T = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] alu_out;
  logic [4:0]   rd;
  logic         mem_we_me;
  logic         me_we;
  logic         mem_reg_me;
  logic [W-1:0] wd_me;
  logic [W-1:0] bp_mem;
  logic         mem_stall;
  logic [W-1:0] wb_data;
  logic [4:0]   wb_rd;
  logic         wb_we;
  logic         misalign;
  logic         bus_err;
  logic         dbg_state;

  memory_stage_if #(.W(W)) dm_if ();

  memory_stage #(.INST_SIZE(W), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .ALU_OUT(alu_out), .RD(rd), .MEM_WE_ME(mem_we_me), .ME_WE(me_we),
    .MEM_REG_ME(mem_reg_me), .WD_ME(wd_me),
    .dm(dm_if.master),
    .BP_MEM(bp_mem), .MEM_STALL(mem_stall),
    .WB_DATA(wb_data), .WB_RD(wb_rd), .WB_WE(wb_we),
    .MISALIGN(misalign), .BUS_ERR(bus_err), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard of expected writebacks {rd, data}
  logic [W+4:0] exp_q[$];

  // observations gathered by run_op
  int           obs_stall;
  int           obs_req;
  int           obs_wb_mid;
  logic         obs_we;
  logic [W-1:0] obs_addr;
  logic [W-1:0] obs_wdata;

  // ---------------- driver ----------------
  // Drives one EX/MEM op until it leaves MEM. ack_at is the cycle index
  // (0 = cycle of entry) in which the memory acks; -1 never acks.
  task automatic run_op(input logic [W-1:0] a, input logic [4:0] r,
                        input logic st, input logic ld, input logic we,
                        input logic [W-1:0] wd, input int ack_at,
                        input logic [W-1:0] rdata);
    int  cyc;
    logic last_stall;
    cyc = 0; obs_stall = 0; obs_req = 0; obs_wb_mid = 0;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
    forever begin
      @(negedge clk);
      alu_out = a; rd = r; mem_we_me = st; mem_reg_me = ld; me_we = we; wd_me = wd;
      dm_if.DM_ACK   = (cyc == ack_at);
      dm_if.DM_RDATA = rdata;
      #1;
      if (cyc > 0 && wb_we === 1'b1) obs_wb_mid++;
      if (dm_if.DM_REQ === 1'b1) begin
        if (obs_req == 0) begin
          obs_we = dm_if.DM_WE; obs_addr = dm_if.DM_ADDR; obs_wdata = dm_if.DM_WDATA;
        end
        obs_req++;
      end
      last_stall = mem_stall;
      if (mem_stall === 1'b1) obs_stall++;
      @(posedge clk);
      cyc++;
      if (last_stall !== 1'b1) break;
      if (cyc >= 50) begin
        n_checks++;
        $display("FAIL op_bound stall still %b after %0d cycles, required 0", last_stall, cyc);
        break;
      end
    end
    #1;
    dm_if.DM_ACK = 1'b0;
  endtask

  task automatic nop();
    run_op('0, 5'd0, 1'b0, 1'b0, 1'b0, '0, -1, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    alu_out = 32'h40; rd = 5'd7; mem_we_me = 1'b0; mem_reg_me = 1'b1; me_we = 1'b1;
    wd_me = '0; dm_if.DM_ACK = 1'b0; dm_if.DM_RDATA = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (dm_if.DM_REQ !== 1'b0) $display("FAIL rst_req got %b exp 0", dm_if.DM_REQ); else n_pass++;
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", mem_stall); else n_pass++;
    n_checks++; if ({wb_data, wb_rd, wb_we} !== '0) $display("FAIL rst_wb got %h/%h/%b exp 0", wb_data, wb_rd, wb_we); else n_pass++;
    n_checks++; if ({misalign, bus_err, dbg_state} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {misalign, bus_err, dbg_state}); else n_pass++;
    rst = 1'b0;
    nop();
  endtask

  task automatic test_alu_op();
    run_op(32'h1234, 5'd5, 1'b0, 1'b0, 1'b1, '0, -1, '0);
    n_checks++; if (wb_data !== 32'h1234) $display("FAIL alu_data got %h exp 1234", wb_data); else n_pass++;
    n_checks++; if (wb_rd !== 5'd5) $display("FAIL alu_rd got %0d exp 5", wb_rd); else n_pass++;
    n_checks++; if (wb_we !== 1'b1) $display("FAIL alu_we got %b exp 1", wb_we); else n_pass++;
    n_checks++; if (obs_stall != 0 || obs_req != 0) $display("FAIL alu_stall_req got %0d/%0d exp 0/0", obs_stall, obs_req); else n_pass++;
  endtask

  task automatic test_load_wait();
    run_op(32'h40, 5'd9, 1'b0, 1'b1, 1'b1, '0, 3, 32'hDEADBEEF);
    n_checks++; if (obs_stall != 3) $display("FAIL ldw_stall got %0d exp 3", obs_stall); else n_pass++;
    n_checks++; if (obs_req != 4 || obs_we !== 1'b0 || obs_addr !== 32'h40) $display("FAIL ldw_req got %0d/%b/%h exp 4/0/40", obs_req, obs_we, obs_addr); else n_pass++;
    n_checks++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd9, 32'hDEADBEEF}) $display("FAIL ldw_wb got %b/%0d/%h exp 1/9/deadbeef", wb_we, wb_rd, wb_data); else n_pass++;
    n_checks++; if (obs_wb_mid != 0) $display("FAIL ldw_bubble got %0d exp 0", obs_wb_mid); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL ldw_idle got %b exp 0", dbg_state); else n_pass++;
  endtask

  task automatic test_store_zero_wait();
    run_op(32'h80, 5'd3, 1'b1, 1'b0, 1'b1, 32'hCAFE, 0, 32'h5555);
    n_checks++; if (obs_req != 1 || obs_stall != 0) $display("FAIL st_req_stall got %0d/%0d exp 1/0", obs_req, obs_stall); else n_pass++;
    n_checks++; if ({obs_we, obs_addr, obs_wdata} !== {1'b1, 32'h80, 32'hCAFE}) $display("FAIL st_bus got %b/%h/%h exp 1/80/cafe", obs_we, obs_addr, obs_wdata); else n_pass++;
    n_checks++; if (wb_we !== 1'b0) $display("FAIL st_we got %b exp 0", wb_we); else n_pass++;
  endtask

  task automatic test_misalign();
    run_op(32'h42, 5'd4, 1'b0, 1'b1, 1'b1, '0, -1, '0);
    n_checks++; if (obs_req != 0 || obs_stall != 0) $display("FAIL mis_req_stall got %0d/%0d exp 0/0", obs_req, obs_stall); else n_pass++;
    n_checks++; if ({misalign, bus_err, wb_we} !== 3'b100) $display("FAIL mis_flags got %b exp 100", {misalign, bus_err, wb_we}); else n_pass++;
    nop();
    n_checks++; if (misalign !== 1'b0) $display("FAIL mis_pulse got %b exp 0", misalign); else n_pass++;
  endtask

  task automatic test_timeout();
    run_op(32'h100, 5'd6, 1'b0, 1'b1, 1'b1, '0, -1, 32'h1);
    n_checks++; if (obs_stall != T) $display("FAIL to_stall got %0d exp %0d", obs_stall, T); else n_pass++;
    n_checks++; if (obs_req != T + 1) $display("FAIL to_req got %0d exp %0d", obs_req, T + 1); else n_pass++;
    n_checks++; if ({bus_err, misalign, wb_we, dbg_state} !== 4'b1000) $display("FAIL to_flags got %b exp 1000", {bus_err, misalign, wb_we, dbg_state}); else n_pass++;
    nop();
    n_checks++; if (bus_err !== 1'b0) $display("FAIL to_pulse got %b exp 0", bus_err); else n_pass++;
  endtask

  task automatic test_both_set();
    run_op(32'h44, 5'd8, 1'b1, 1'b1, 1'b1, 32'h77, 1, 32'h99);
    n_checks++; if (obs_we !== 1'b1 || obs_stall != 1) $display("FAIL both_we_stall got %b/%0d exp 1/1", obs_we, obs_stall); else n_pass++;
    n_checks++; if (wb_we !== 1'b0) $display("FAIL both_wb_we got %b exp 0", wb_we); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    run_op(32'h1234, 5'd5, 1'b0, 1'b0, 1'b1, '0, -1, '0);
    @(negedge clk);
    alu_out = 32'h40; rd = 5'd2; mem_we_me = 1'b0; mem_reg_me = 1'b1; me_we = 1'b1;
    dm_if.DM_ACK = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (dbg_state !== 1'b1 || mem_stall !== 1'b1) $display("FAIL rmw_waiting got %b/%b exp 1/1", dbg_state, mem_stall); else n_pass++;
    rst = 1'b1; #1;
    n_checks++; if (dm_if.DM_REQ !== 1'b0 || mem_stall !== 1'b0) $display("FAIL rmw_forced got %b/%b exp 0/0", dm_if.DM_REQ, mem_stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({wb_data, wb_rd, wb_we, bus_err, dbg_state} !== '0) $display("FAIL rmw_cleared got %h/%h/%b/%b/%b exp 0", wb_data, wb_rd, wb_we, bus_err, dbg_state); else n_pass++;
    @(negedge clk);
    rst = 1'b0; mem_reg_me = 1'b0; me_we = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus_err !== 1'b0 || dbg_state !== 1'b0) $display("FAIL rmw_after got %b/%b exp 0/0", bus_err, dbg_state); else n_pass++;
  endtask

  // Transaction-level model: an aligned access acked in cycle d completes
  // after d stall cycles if d <= T, otherwise it is aborted after T stalls.
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, wd, rdat;
      logic [4:0]   r;
      logic         st, ld, we, acc, mis, exp_we, exp_mis, exp_err;
      int           kind, ack_at, exp_stall, exp_req;
      logic [W-1:0] exp_data;
      kind = $urandom_range(0, 3);
      st = (kind >= 2); ld = (kind == 1) || (kind == 3);
      a = $urandom; wd = $urandom; rdat = $urandom;
      r = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      acc = st | ld;
      mis = acc && (a % 4 != 0);
      ack_at = (acc && !mis) ? $urandom_range(0, 6) : -1;
      exp_mis = 1'b0; exp_err = 1'b0; exp_we = 1'b0; exp_stall = 0; exp_req = 0;
      exp_data = (ld && !st) ? rdat : a;
      if (!acc) begin
        exp_we = we && (r != 0);
      end else if (mis) begin
        exp_mis = 1'b1;
      end else if (ack_at <= T) begin
        exp_stall = ack_at; exp_req = ack_at + 1;
        exp_we = we && (r != 0) && !st;
      end else begin
        exp_stall = T; exp_req = T + 1; exp_err = 1'b1;
      end
      if (exp_we) exp_q.push_back({r, exp_data});
      run_op(a, r, st, ld, we, wd, ack_at, rdat);
      n_checks++; if (obs_stall != exp_stall || obs_req != exp_req) $display("FAIL rnd%0d_stall_req got %0d/%0d exp %0d/%0d", i, obs_stall, obs_req, exp_stall, exp_req); else n_pass++;
      n_checks++; if ({wb_we, misalign, bus_err} !== {exp_we, exp_mis, exp_err}) $display("FAIL rnd%0d_flags got %b exp %b", i, {wb_we, misalign, bus_err}, {exp_we, exp_mis, exp_err}); else n_pass++;
      if (exp_req > 0) begin
        n_checks++; if ({obs_we, obs_addr} !== {st, a} || (st && obs_wdata !== wd)) $display("FAIL rnd%0d_bus got %b/%h/%h exp %b/%h/%h", i, obs_we, obs_addr, obs_wdata, st, a, wd); else n_pass++;
      end
      if (wb_we === 1'b1 && exp_q.size() > 0) begin
        logic [W+4:0] e;
        e = exp_q.pop_front();
        n_checks++; if ({wb_rd, wb_data} !== e) $display("FAIL rnd%0d_wb got %h exp %h", i, {wb_rd, wb_data}, e); else n_pass++;
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_leftover got %0d exp 0", exp_q.size()); else n_pass++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store_zero_wait();
    test_misalign();
    test_timeout();
    test_both_set();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
